jtframe_rom_nslot_cache: RTL and testbench

Parametrised successor to the single-slot ROM bank reader. Shares one SDRAM read bank among up to four ROM clients of independent width, address size and bank offset. Each slot has a one-word hit cache. A fixed-priority or round-robin arbiter issues the SDRAM reads. Sits between game-core ROM clients and one ba_* port of the SDRAM controller.

---
 rtl/jtframe_rom_nslot_cache.sv | 177 +++++++++++++++++
 tb/tb_jtframe_rom_nslot_cache.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_nslot_cache.sv
// Shares one SDRAM read bank among up to four ROM slots, each holding a one-word hit cache.
// A fixed-priority or round-robin arbiter keeps a single read outstanding at a time.
module jtframe_rom_nslot_cache #(
  parameter int          SLOTS        = 2,
  parameter int          SLOT0_DW     = 8,
  parameter int          SLOT1_DW     = 8,
  parameter int          SLOT2_DW     = 8,
  parameter int          SLOT3_DW     = 8,
  parameter int          SLOT0_AW     = 16,
  parameter int          SLOT1_AW     = 16,
  parameter int          SLOT2_AW     = 16,
  parameter int          SLOT3_AW     = 16,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0,
  parameter int          RR           = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot1_ok,
  input  logic                slot2_cs,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  output logic [SLOT2_DW-1:0] slot2_dout,
  output logic                slot2_ok,
  input  logic                slot3_cs,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  output logic [SLOT3_DW-1:0] slot3_dout,
  output logic                slot3_ok,
  output logic [21:0]         sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int          DW [4]  = '{SLOT0_DW, SLOT1_DW, SLOT2_DW, SLOT3_DW};
  localparam logic [21:0] OFS [4] = '{SLOT0_OFFSET, SLOT1_OFFSET, SLOT2_OFFSET, SLOT3_OFFSET};
  localparam logic [3:0]  EN      = 4'((1 << SLOTS) - 1);

  state_t      r_state, w_next;
  logic [31:0] w_araw  [4];
  logic [21:0] w_waddr [4];
  logic [31:0] w_dout  [4];
  logic [21:0] r_tag   [4];
  logic [31:0] r_data  [4];
  logic [3:0]  w_cs, w_hit, w_miss, r_valid;
  logic [1:0]  r_slot, w_win;
  logic        w_found;
  int          w_idx;
  logic [31:0] r_buf, w_fill;
  logic        r_cnt;
  logic [21:0] r_addr;
  logic        r_req;

  assign w_araw[0] = 32'(slot0_addr);
  assign w_araw[1] = 32'(slot1_addr);
  assign w_araw[2] = 32'(slot2_addr);
  assign w_araw[3] = 32'(slot3_addr);
  assign w_cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};

  // Per-slot word address, hit test and data lane selection
  for (genvar n = 0; n < 4; n++) begin : g_slot
    assign w_waddr[n] = ((DW[n] == 8)  ? 22'(w_araw[n] >> 1) :
                         (DW[n] == 32) ? 22'(w_araw[n] << 1) :
                                         22'(w_araw[n])) + OFS[n];
    assign w_hit[n]   = EN[n] & w_cs[n] & r_valid[n] & (r_tag[n] == w_waddr[n]);
    assign w_dout[n]  = !EN[n]        ? 32'd0 :
                        (DW[n] == 8)  ? {24'd0, (w_araw[n][0] ? r_data[n][15:8] : r_data[n][7:0])} :
                        (DW[n] == 16) ? {16'd0, r_data[n][15:0]} :
                                        r_data[n];
  end

  assign w_miss     = EN & w_cs & ~w_hit;
  assign slot0_ok   = w_hit[0];
  assign slot1_ok   = w_hit[1];
  assign slot2_ok   = w_hit[2];
  assign slot3_ok   = w_hit[3];
  assign slot0_dout = w_dout[0][SLOT0_DW-1:0];
  assign slot1_dout = w_dout[1][SLOT1_DW-1:0];
  assign slot2_dout = w_dout[2][SLOT2_DW-1:0];
  assign slot3_dout = w_dout[3][SLOT3_DW-1:0];
  assign sdram_addr = r_addr;
  assign sdram_req  = r_req;

  // Round-robin search starts just after the slot served last
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < SLOTS) begin
        w_idx = (RR != 0) ? int'(r_slot) + 1 + k : k;
        if (w_idx >= SLOTS) w_idx = w_idx - SLOTS;
        if (!w_found && w_miss[w_idx[1:0]]) begin
          w_found = 1'b1;
          w_win   = w_idx[1:0];
        end
      end
    end
  end

  always_comb begin
    w_fill = r_buf;
    if (data_dst) begin
      if (r_cnt) w_fill[31:16] = data_read;
      else       w_fill[15:0]  = data_read;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found)   w_next = REQ;
      REQ:     if (sdram_ack) w_next = WAIT;
      WAIT:    if (data_rdy)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A fill in the same cycle as flush re-validates its own slot after the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 4'd0;
      r_slot  <= 2'd0;
      r_addr  <= 22'd0;
      r_req   <= 1'b0;
      r_cnt   <= 1'b0;
      r_buf   <= 32'd0;
      for (int n = 0; n < 4; n++) begin
        r_tag[n]  <= 22'd0;
        r_data[n] <= 32'd0;
      end
    end else begin
      if (flush) r_valid <= 4'd0;
      case (r_state)
        IDLE: if (w_found) begin
          r_slot <= w_win;
          r_addr <= w_waddr[w_win];
          r_req  <= 1'b1;
          r_cnt  <= 1'b0;
          r_buf  <= 32'd0;
        end
        REQ: if (sdram_ack) r_req <= 1'b0;
        WAIT: begin
          if (data_dst) begin
            r_buf <= w_fill;
            r_cnt <= 1'b1;
          end
          if (data_rdy) begin
            r_data[r_slot]  <= w_fill;
            r_tag[r_slot]   <= r_addr;
            r_valid[r_slot] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_rom_nslot_cache.sv
// Directed bench: one fixed-priority cache (DW8 + DW32 slots) and one round-robin
// cache (two DW16 slots) share the SDRAM-side inputs driven by the bench.
module tb_jtframe_rom_nslot_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        sdAck = 1'b0, dataDst = 1'b0, dataRdy = 1'b0;
  logic [15:0] dataRead = 16'h0;

  logic        cs0 = 1'b0, cs1 = 1'b0;
  logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
  logic [7:0]  dout0, dout2, dout3;
  logic [31:0] dout1;
  logic        ok0, ok1, ok2, ok3;
  logic [21:0] sdAddr;
  logic        sdReq;

  logic        rCs0 = 1'b0, rCs1 = 1'b0;
  logic [15:0] rAddr0 = 16'h0, rAddr1 = 16'h0;
  logic [15:0] rDout0, rDout1;
  logic [7:0]  rDout2, rDout3;
  logic        rOk0, rOk1, rOk2, rOk3;
  logic [21:0] rSdAddr;
  logic        rSdReq;

  int checks = 0;
  int errors = 0;
  logic [21:0] gotAddr;

  always #5 clk = ~clk;

  jtframe_rom_nslot_cache #(
    .SLOTS(2), .SLOT0_DW(8), .SLOT1_DW(32),
    .SLOT1_OFFSET(22'h100000), .RR(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .slot0_cs(cs0), .slot0_addr(addr0), .slot0_dout(dout0), .slot0_ok(ok0),
    .slot1_cs(cs1), .slot1_addr(addr1), .slot1_dout(dout1), .slot1_ok(ok1),
    .slot2_cs(1'b0), .slot2_addr(16'h0), .slot2_dout(dout2), .slot2_ok(ok2),
    .slot3_cs(1'b0), .slot3_addr(16'h0), .slot3_dout(dout3), .slot3_ok(ok3),
    .sdram_addr(sdAddr), .sdram_req(sdReq), .sdram_ack(sdAck),
    .data_dst(dataDst), .data_rdy(dataRdy), .data_read(dataRead)
  );

  jtframe_rom_nslot_cache #(
    .SLOTS(2), .SLOT0_DW(16), .SLOT1_DW(16),
    .SLOT1_OFFSET(22'h200), .RR(1)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .slot0_cs(rCs0), .slot0_addr(rAddr0), .slot0_dout(rDout0), .slot0_ok(rOk0),
    .slot1_cs(rCs1), .slot1_addr(rAddr1), .slot1_dout(rDout1), .slot1_ok(rOk1),
    .slot2_cs(1'b1), .slot2_addr(16'h0), .slot2_dout(rDout2), .slot2_ok(rOk2),
    .slot3_cs(1'b0), .slot3_addr(16'h0), .slot3_dout(rDout3), .slot3_ok(rOk3),
    .sdram_addr(rSdAddr), .sdram_req(rSdReq), .sdram_ack(sdAck),
    .data_dst(dataDst), .data_rdy(dataRdy), .data_read(dataRead)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic c0, input logic [15:0] a0,
                               input logic c1, input logic [15:0] a1);
    cs0 = c0; addr0 = a0; cs1 = c1; addr1 = a1;
  endtask

  // Waits for a request from the selected cache and returns its address
  task automatic waitReq(input bit sel, output logic [21:0] a);
    bit seen;
    seen = 1'b0;
    a = 22'h0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? rSdReq : sdReq) == 1'b1) begin
        seen = 1'b1;
        a = sel ? rSdAddr : sdAddr;
      end
    end
    checkOutput("reqSeen", 32'(seen), 32'd1);
  endtask

  task automatic doAck(input bit sel);
    sdAck = 1'b1;
    @(negedge clk);
    sdAck = 1'b0;
    checkOutput("reqFall", 32'(sel ? rSdReq : sdReq), 32'd0);
  endtask

  // Returns on the negedge right after the cycle that carried data_rdy
  task automatic sendData(input logic [15:0] w0, input logic [15:0] w1, input bit two);
    @(negedge clk);
    dataDst = 1'b1; dataRead = w0; dataRdy = !two;
    @(negedge clk);
    if (two) begin
      dataRead = w1; dataRdy = 1'b1;
      @(negedge clk);
    end
    dataDst = 1'b0; dataRdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rstReq",   32'(sdReq),  32'd0);
    checkOutput("rstAddr",  32'(sdAddr), 32'd0);
    checkOutput("rstOk0",   32'(ok0),    32'd0);
    checkOutput("rstDout0", 32'(dout0),  32'd0);
    checkOutput("rstDout1", dout1,       32'd0);
    checkOutput("rstRrOk2", 32'(rOk2),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single DW8 miss, then a byte-lane switch within the same word
    applyStimulus(1'b1, 16'h0003, 1'b0, 16'h0);
    waitReq(0, gotAddr);
    checkOutput("t1Addr", 32'(gotAddr), 32'h000001);
    doAck(0);
    checkOutput("t1OkWait", 32'(ok0), 32'd0);
    sendData(16'hA55A, 16'h0, 0);
    checkOutput("t1Ok",   32'(ok0),   32'd1);
    checkOutput("t1Dout", 32'(dout0), 32'h000000A5);
    applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0);
    #1;
    checkOutput("t1OkLo",   32'(ok0),   32'd1);
    checkOutput("t1DoutLo", 32'(dout0), 32'h0000005A);
    @(negedge clk);
    checkOutput("t1NoReq", 32'(sdReq), 32'd0);

    // DW32 slot with offset, two data words
    applyStimulus(1'b1, 16'h0002, 1'b1, 16'h0010);
    waitReq(0, gotAddr);
    checkOutput("t2Addr", 32'(gotAddr), 32'h100020);
    doAck(0);
    sendData(16'h1234, 16'hABCD, 1);
    checkOutput("t2Ok",   32'(ok1), 32'd1);
    checkOutput("t2Dout", dout1,    32'hABCD1234);
    checkOutput("t2Ok0",  32'(ok0), 32'd1);

    // Simultaneous misses, fixed priority: slot0 first
    applyStimulus(1'b1, 16'h0100, 1'b1, 16'h0020);
    waitReq(0, gotAddr);
    checkOutput("t3First", 32'(gotAddr), 32'h000080);
    doAck(0);
    sendData(16'h1111, 16'h0, 0);
    checkOutput("t3Ok0",   32'(ok0),   32'd1);
    checkOutput("t3Dout0", 32'(dout0), 32'h11);
    waitReq(0, gotAddr);
    checkOutput("t3Second", 32'(gotAddr), 32'h100040);
    doAck(0);
    sendData(16'h2222, 16'h3333, 1);
    checkOutput("t3Ok1",   32'(ok1), 32'd1);
    checkOutput("t3Dout1", dout1,    32'h33332222);

    // Flush clears both slots, then both refetch in priority order
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t5Ok0", 32'(ok0), 32'd0);
    checkOutput("t5Ok1", 32'(ok1), 32'd0);
    waitReq(0, gotAddr);
    checkOutput("t5Re0", 32'(gotAddr), 32'h000080);
    doAck(0);
    sendData(16'h1111, 16'h0, 0);
    waitReq(0, gotAddr);
    checkOutput("t5Re1", 32'(gotAddr), 32'h100040);
    doAck(0);
    sendData(16'h2222, 16'h3333, 1);
    checkOutput("t5Ok0b", 32'(ok0), 32'd1);
    checkOutput("t5Ok1b", 32'(ok1), 32'd1);

    // Address change while waiting for data: fill uses the latched tag
    applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0020);
    waitReq(0, gotAddr);
    checkOutput("t4Addr", 32'(gotAddr), 32'h000008);
    doAck(0);
    applyStimulus(1'b1, 16'h0020, 1'b0, 16'h0020);
    sendData(16'hBEEF, 16'h0, 0);
    checkOutput("t4NoStale", 32'(ok0), 32'd0);
    waitReq(0, gotAddr);
    checkOutput("t4Refetch", 32'(gotAddr), 32'h000010);
    doAck(0);
    sendData(16'h7788, 16'h0, 0);
    checkOutput("t4Ok",   32'(ok0),   32'd1);
    checkOutput("t4Dout", 32'(dout0), 32'h88);
    applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0020);
    #1;
    checkOutput("t4OldWord", 32'(ok0), 32'd0);
    applyStimulus(1'b0, 16'h0010, 1'b0, 16'h0020);

    // Async reset during REQ, then a stray data_rdy must not fill
    @(negedge clk);
    applyStimulus(1'b1, 16'h0030, 1'b0, 16'h0);
    waitReq(0, gotAddr);
    checkOutput("t6Addr", 32'(gotAddr), 32'h000018);
    rst_n = 1'b0;
    #1;
    checkOutput("t6ReqAsync",  32'(sdReq),  32'd0);
    checkOutput("t6AddrAsync", 32'(sdAddr), 32'd0);
    applyStimulus(1'b0, 16'h0030, 1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dataDst = 1'b1; dataRdy = 1'b1; dataRead = 16'h9999;
    @(negedge clk);
    dataDst = 1'b0; dataRdy = 1'b0;
    applyStimulus(1'b1, 16'h0030, 1'b0, 16'h0);
    #1;
    checkOutput("t6StrayOk",   32'(ok0),   32'd0);
    checkOutput("t6StrayDout", 32'(dout0), 32'd0);
    applyStimulus(1'b0, 16'h0030, 1'b0, 16'h0);

    // Round-robin: search starts after the last served slot
    @(negedge clk);
    rCs0 = 1'b1; rCs1 = 1'b1; rAddr0 = 16'h0040; rAddr1 = 16'h0040;
    waitReq(1, gotAddr);
    checkOutput("rrFirst", 32'(gotAddr), 32'h000240);
    doAck(1);
    sendData(16'h5151, 16'h0, 0);
    waitReq(1, gotAddr);
    checkOutput("rrSecond", 32'(gotAddr), 32'h000040);
    doAck(1);
    sendData(16'h4040, 16'h0, 0);
    checkOutput("rrOk0",   32'(rOk0),   32'd1);
    checkOutput("rrDout0", 32'(rDout0), 32'h4040);
    checkOutput("rrOk1",   32'(rOk1),   32'd1);
    checkOutput("rrDout1", 32'(rDout1), 32'h5151);
    checkOutput("rrOk2",   32'(rOk2),   32'd0);
    rAddr0 = 16'h0041; rAddr1 = 16'h0041;
    waitReq(1, gotAddr);
    checkOutput("rrThird", 32'(gotAddr), 32'h000241);
    doAck(1);
    sendData(16'h5252, 16'h0, 0);
    waitReq(1, gotAddr);
    checkOutput("rrFourth", 32'(gotAddr), 32'h000041);
    doAck(1);
    sendData(16'h4141, 16'h0, 0);
    checkOutput("rrOk0b", 32'(rOk0), 32'd1);
    checkOutput("rrOk1b", 32'(rOk1), 32'd1);
    rCs0 = 1'b0; rCs1 = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
